// File: rtl/sparc_regfile_pkg.sv
// Shared constants for the SPARC V8 windowed register file.
//
// Architectural register classes (r0..r31) are split into four groups of
// eight: globals, outs, locals, ins. Physically the globals sit at 0..7 and
// every window adds a 16-entry slice (outs + locals). A window's ins are the
// outs of the next-higher window, so they live in that window's slice.
//
// Contents:
//   G_BASE/O_BASE/L_BASE/I_BASE  first architectural number of each class
//   CLASS_SIZE                   registers per class
//   WIN_STRIDE                   physical registers added per window
//   phys_count()                 physical register count for N windows
//   cwp_width()                  CWP width for N windows (minimum 1)
package sparc_regfile_pkg;

    localparam int G_BASE     = 0;
    localparam int O_BASE     = 8;
    localparam int L_BASE     = 16;
    localparam int I_BASE     = 24;
    localparam int CLASS_SIZE = 8;
    localparam int WIN_STRIDE = 16;

    // Globals occupy the bottom of the physical array, so window 0 starts
    // right after them.
    localparam int WIN0_BASE  = CLASS_SIZE;

    function automatic int phys_count(input int nwindows);
        return WIN0_BASE + WIN_STRIDE * nwindows;
    endfunction

    function automatic int cwp_width(input int nwindows);
        return (nwindows <= 2) ? 1 : $clog2(nwindows);
    endfunction

endpackage

// File: rtl/windowed_reg_decoder_if.sv
// Bus between the decode/writeback stage (master) and the windowed
// write-select decoder (slave).
//
// Signals:
//   wr_en, rd_addr            writeback request for architectural register
//   save, restore             window rotation requests
//   cwp_we, cwp_in            direct CWP load
//   wim                       window invalid mask
//   phys_we, phys_idx         registered one-hot / binary physical select
//   cwp                       current window pointer
//   window_ovf, window_unf    one-cycle pulses for blocked SAVE / RESTORE
//
// Handshake: there is no flow control. Every input is sampled on each rising
// clock edge and all outputs are registered and valid one cycle later.
interface windowed_reg_decoder_if #(
    parameter int NWINDOWS = 4
);
    import sparc_regfile_pkg::*;

    localparam int PHYS  = phys_count(NWINDOWS);
    localparam int CWP_W = cwp_width(NWINDOWS);
    localparam int IDX_W = $clog2(PHYS);

    logic                wr_en;
    logic [4:0]          rd_addr;
    logic                save;
    logic                restore;
    logic                cwp_we;
    logic [CWP_W-1:0]    cwp_in;
    logic [NWINDOWS-1:0] wim;
    logic [PHYS-1:0]     phys_we;
    logic [IDX_W-1:0]    phys_idx;
    logic [CWP_W-1:0]    cwp;
    logic                window_ovf;
    logic                window_unf;

    modport master (
        output wr_en, rd_addr, save, restore, cwp_we, cwp_in, wim,
        input  phys_we, phys_idx, cwp, window_ovf, window_unf
    );

    modport slave (
        input  wr_en, rd_addr, save, restore, cwp_we, cwp_in, wim,
        output phys_we, phys_idx, cwp, window_ovf, window_unf
    );

endinterface

// File: rtl/onehot_decoder.sv
// Combinational binary -> one-hot decoder with enable.
//
// Ports:
//   bin_i     binary index
//   en_i      when low the output is all zeros
//   onehot_o  one-hot result; indices >= OUT_W produce all zeros
module onehot_decoder #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 72
) (
    input  logic [IN_W-1:0]  bin_i,
    input  logic             en_i,
    output logic [OUT_W-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < OUT_W; i++) begin
            if (en_i && (bin_i == IN_W'(i))) begin
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/windowed_reg_decoder.sv
// Register-file write-select decoder with SPARC V8 register windows.
//
// Maps a 5-bit architectural register number plus the current window
// pointer to a registered one-hot write enable (and matching binary index)
// over the physical register array. Holds CWP and rotates it on SAVE /
// RESTORE, optionally blocking rotation into windows marked in WIM.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; overrides every input
//   bus    windowed_reg_decoder_if.slave (see the interface for signals)
//
// Configuration macro WINDOW_CHECK_EN:
//   defined   - SAVE/RESTORE into a WIM-marked window is blocked and pulses
//               window_ovf / window_unf for one cycle.
//   undefined - wim is ignored, flags stay 0, SAVE/RESTORE always rotate.
module windowed_reg_decoder
    import sparc_regfile_pkg::*;
#(
    parameter int NWINDOWS = 4
) (
    input logic                    clk,
    input logic                    reset,
    windowed_reg_decoder_if.slave  bus
);

    localparam int PHYS  = phys_count(NWINDOWS);
    localparam int CWP_W = cwp_width(NWINDOWS);
    localparam int IDX_W = $clog2(PHYS);

    logic [CWP_W-1:0] cwp_q, cwp_d;
    logic [CWP_W-1:0] save_tgt, restore_tgt;
    logic [IDX_W-1:0] idx_d, phys_idx_q;
    logic [PHYS-1:0]  onehot_d, phys_we_q;
    logic             dec_en;
    logic             ovf_d, ovf_q;
    logic             unf_d, unf_q;
    logic [1:0]       rd_class;
    logic [2:0]       rd_off;

    // Physical base of a window's 16-entry slice.
    function automatic logic [IDX_W-1:0] win_base(input logic [CWP_W-1:0] w);
        return IDX_W'(WIN0_BASE) + IDX_W'(WIN_STRIDE) * IDX_W'(w);
    endfunction

    // Neighbouring windows with modulo-NWINDOWS wrap.
    assign save_tgt    = (cwp_q == '0) ? CWP_W'(NWINDOWS - 1) : cwp_q - 1'b1;
    assign restore_tgt = (cwp_q == CWP_W'(NWINDOWS - 1)) ? '0 : cwp_q + 1'b1;

    assign rd_class = bus.rd_addr[4:3];
    assign rd_off   = bus.rd_addr[2:0];

    // r0 is hardwired zero, so a write to it selects nothing.
    assign dec_en = bus.wr_en && (bus.rd_addr != 5'd0);

    // Architectural -> physical mapping, always using the pre-edge cwp.
    // The ins of window w are the outs of window w+1, which is exactly
    // restore_tgt.
    always_comb begin
        idx_d = '0;
        case (rd_class)
            2'd0:    idx_d = IDX_W'(G_BASE) + IDX_W'(rd_off);
            2'd1:    idx_d = win_base(cwp_q) + IDX_W'(rd_off);
            2'd2:    idx_d = win_base(cwp_q) + IDX_W'(CLASS_SIZE) + IDX_W'(rd_off);
            default: idx_d = win_base(restore_tgt) + IDX_W'(rd_off);
        endcase
    end

    onehot_decoder #(
        .IN_W  (IDX_W),
        .OUT_W (PHYS)
    ) u_onehot (
        .bin_i    (idx_d),
        .en_i     (dec_en),
        .onehot_o (onehot_d)
    );

    // CWP update: direct load beats rotation; simultaneous save+restore is
    // treated as a no-op.
    always_comb begin
        cwp_d = cwp_q;
        ovf_d = 1'b0;
        unf_d = 1'b0;
        if (bus.cwp_we) begin
            // Out-of-range loads are dropped rather than aliased.
            if (bus.cwp_in <= CWP_W'(NWINDOWS - 1)) begin
                cwp_d = bus.cwp_in;
            end
        end else if (bus.save && bus.restore) begin
            cwp_d = cwp_q;
        end else if (bus.save) begin
`ifdef WINDOW_CHECK_EN
            if (bus.wim[save_tgt]) begin
                ovf_d = 1'b1;
            end else begin
                cwp_d = save_tgt;
            end
`else
            cwp_d = save_tgt;
`endif
        end else if (bus.restore) begin
`ifdef WINDOW_CHECK_EN
            if (bus.wim[restore_tgt]) begin
                unf_d = 1'b1;
            end else begin
                cwp_d = restore_tgt;
            end
`else
            cwp_d = restore_tgt;
`endif
        end
    end

`ifndef WINDOW_CHECK_EN
    logic unused_wim;
    assign unused_wim = ^bus.wim;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            phys_we_q  <= '0;
            phys_idx_q <= '0;
            cwp_q      <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            phys_we_q  <= onehot_d;
            phys_idx_q <= dec_en ? idx_d : '0;
            cwp_q      <= cwp_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.phys_we    = phys_we_q;
    assign bus.phys_idx   = phys_idx_q;
    assign bus.cwp        = cwp_q;
    assign bus.window_ovf = ovf_q;
    assign bus.window_unf = unf_q;

endmodule

// File: tb/tb_windowed_reg_decoder.sv
// Directed bench for windowed_reg_decoder at NWINDOWS=4 (PHYS=72).
// Expected values are hand-derived from the window mapping:
//   base(w) = 8 + 16*w; outs base+0..7, locals base+8..15,
//   ins base((w+1) mod 4)+0..7.
module tb_windowed_reg_decoder;

    localparam int NW = 4;

    logic clk;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    windowed_reg_decoder_if #(.NWINDOWS(NW)) bus ();

    windowed_reg_decoder #(.NWINDOWS(NW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [127:0] oh(input int k);
        logic [127:0] one;
        one = 128'd1;
        return one << k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        bus.wr_en   = 1'b0;
        bus.rd_addr = 5'd0;
        bus.save    = 1'b0;
        bus.restore = 1'b0;
        bus.cwp_we  = 1'b0;
        bus.cwp_in  = '0;
        bus.wim     = '0;
    endtask

    task automatic drive_wr(input logic en, input logic [4:0] rd);
        bus.wr_en   = en;
        bus.rd_addr = rd;
    endtask

    initial begin
        int exp_cwp;

        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        check("rst_we",  bus.phys_we, 0);
        check("rst_idx", bus.phys_idx, 0);
        check("rst_cwp", bus.cwp, 0);
        check("rst_ovf", bus.window_ovf, 0);
        check("rst_unf", bus.window_unf, 0);
        reset = 1'b0;

        // Globals, locals, ins at cwp=0
        drive_wr(1'b1, 5'd5);  tick();
        check("g5_we",  bus.phys_we, oh(5));
        check("g5_idx", bus.phys_idx, 5);
        check("g5_cwp", bus.cwp, 0);
        drive_wr(1'b1, 5'd17); tick();
        check("l17_idx", bus.phys_idx, 17);
        check("l17_we",  bus.phys_we, oh(17));
        drive_wr(1'b1, 5'd24); tick();
        check("i24_idx", bus.phys_idx, 24);
        drive_wr(1'b1, 5'd23); tick();
        check("l23_idx", bus.phys_idx, 23);

        // r0 and wr_en=0 select nothing
        drive_wr(1'b1, 5'd0);  tick();
        check("r0_we",  bus.phys_we, 0);
        check("r0_idx", bus.phys_idx, 0);
        drive_wr(1'b0, 5'd12); tick();
        check("noen_we",  bus.phys_we, 0);
        check("noen_idx", bus.phys_idx, 0);

        // SAVE wraps 0 -> 3; concurrent write decodes with old cwp (r8 -> 8)
        drive_wr(1'b1, 5'd8);
        bus.wim  = 4'b0000;
        bus.save = 1'b1;
        tick();
        bus.save = 1'b0;
        check("save_wrap_cwp", bus.cwp, 3);
        check("save_old_idx",  bus.phys_idx, 8);
        check("save_ovf",      bus.window_ovf, 0);

        // cwp=3: ins wrap to window 0, outs at base(3)=56
        drive_wr(1'b1, 5'd24); tick();
        check("c3_i24_idx", bus.phys_idx, 8);
        drive_wr(1'b1, 5'd9);  tick();
        check("c3_o9_idx", bus.phys_idx, 57);
        check("c3_o9_we",  bus.phys_we, oh(57));
        drive_wr(1'b1, 5'd31); tick();
        check("c3_i31_idx", bus.phys_idx, 15);
        drive_wr(1'b0, 5'd0);

        // SAVE into window 2 with wim bit 2 set
        bus.wim  = 4'b0100;
        bus.save = 1'b1;
        tick();
        bus.save = 1'b0;
`ifdef WINDOW_CHECK_EN
        exp_cwp = 3;
        check("ovf_cwp",   bus.cwp, exp_cwp);
        check("ovf_pulse", bus.window_ovf, 1);
`else
        exp_cwp = 2;
        check("noovf_cwp",   bus.cwp, exp_cwp);
        check("noovf_pulse", bus.window_ovf, 0);
`endif
        tick();
        check("ovf_clear", bus.window_ovf, 0);
        check("ovf_hold",  bus.cwp, exp_cwp);
        bus.wim = 4'b0000;

        // save+restore together: no change, no flags
        bus.save    = 1'b1;
        bus.restore = 1'b1;
        tick();
        check("sr_cwp", bus.cwp, exp_cwp);
        check("sr_ovf", bus.window_ovf, 0);
        check("sr_unf", bus.window_unf, 0);

        // cwp_we beats save
        bus.restore = 1'b0;
        bus.cwp_we  = 1'b1;
        bus.cwp_in  = 2'd2;
        tick();
        bus.cwp_we = 1'b0;
        bus.save   = 1'b0;
        check("cwpwe_cwp", bus.cwp, 2);
        check("cwpwe_ovf", bus.window_ovf, 0);

        // RESTORE into window 3 with wim bit 3 set
        bus.wim     = 4'b1000;
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        bus.wim     = 4'b0000;
`ifdef WINDOW_CHECK_EN
        check("unf_cwp",   bus.cwp, 2);
        check("unf_pulse", bus.window_unf, 1);
`else
        check("nounf_cwp",   bus.cwp, 3);
        check("nounf_pulse", bus.window_unf, 0);
`endif
        tick();
        check("unf_clear", bus.window_unf, 0);

        // RESTORE wraps 3 -> 0
        bus.cwp_we = 1'b1;
        bus.cwp_in = 2'd3;
        tick();
        bus.cwp_we  = 1'b0;
        check("load3_cwp", bus.cwp, 3);
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        check("restore_wrap_cwp", bus.cwp, 0);

        // Move to cwp=1, then reset mid-stream with write and save active
        bus.restore = 1'b1;
        tick();
        bus.restore = 1'b0;
        check("restore_cwp1", bus.cwp, 1);
        drive_wr(1'b1, 5'd20);
        bus.save = 1'b1;
        reset    = 1'b1;
        tick();
        check("mrst_we",  bus.phys_we, 0);
        check("mrst_idx", bus.phys_idx, 0);
        check("mrst_cwp", bus.cwp, 0);
        check("mrst_ovf", bus.window_ovf, 0);
        check("mrst_unf", bus.window_unf, 0);
        reset = 1'b0;
        drive_idle();

        // After reset the write path works again at cwp=0 (r20 -> 8+8+4=20)
        drive_wr(1'b1, 5'd20); tick();
        check("post_idx", bus.phys_idx, 20);
        drive_idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
